// File: rtl/pc_sequencer.sv
// Program counter for the single-cycle MIPS datapath.
// Handles stall hold, exception redirect with EPC, a circular return-address
// stack for call/return, and alignment checking of register/RAS targets.
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] reg_addr,
  input  logic [15:0]     branch_offset,
  input  logic [25:0]     jump_addr,
  input  logic            exc_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] epc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_overflow,
  output logic            ras_underflow,
  output logic            misaligned
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  localparam logic [2:0] SEL_SEQ    = 3'b000;
  localparam logic [2:0] SEL_JUMP   = 3'b001;
  localparam logic [2:0] SEL_JREG   = 3'b010;
  localparam logic [2:0] SEL_BRANCH = 3'b011;
  localparam logic [2:0] SEL_CALL   = 3'b100;
  localparam logic [2:0] SEL_RET    = 3'b101;

  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   ptr, ptr_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [XLEN-1:0] pc_n, epc_n;
  logic            push;
  logic            ovf_n, unf_n, mis_n;

  logic [XLEN-1:0] seq, jump_tgt, reg_tgt, br_tgt, top;

  // Candidate targets for every next-PC mode
  always_comb begin
    seq      = pc + XLEN'(4);
    jump_tgt = {pc[XLEN-1:28], jump_addr, 2'b00};
    reg_tgt  = {reg_addr[XLEN-1:2], 2'b00};
    br_tgt   = seq + ({{(XLEN-16){branch_offset[15]}}, branch_offset} << 2);
    top      = ras[ptr];
  end

  // Next-state selection: exception beats stall beats pc_sel
  always_comb begin
    pc_n  = pc;
    epc_n = epc;
    ptr_n = ptr;
    cnt_n = cnt;
    push  = 1'b0;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    mis_n = 1'b0;
    if (exc_req) begin
      epc_n = pc;
      pc_n  = EXC_VECTOR;
    end else if (!stall) begin
      case (pc_sel)
        SEL_JUMP:   pc_n = jump_tgt;
        SEL_JREG: begin
          pc_n  = reg_tgt;
          mis_n = |reg_addr[1:0];
        end
        SEL_BRANCH: pc_n = br_tgt;
        SEL_CALL: begin
          pc_n  = jump_tgt;
          push  = 1'b1;
          ptr_n = ptr + PW'(1);
          // When full, the slot after the top is the oldest entry and gets overwritten
          if (cnt == CW'(RAS_DEPTH)) ovf_n = 1'b1;
          else                       cnt_n = cnt + CW'(1);
        end
        SEL_RET: begin
          if (cnt != '0) begin
            pc_n  = {top[XLEN-1:2], 2'b00};
            mis_n = |top[1:0];
            ptr_n = ptr - PW'(1);
            cnt_n = cnt - CW'(1);
          end else begin
            pc_n  = reg_tgt;
            mis_n = |reg_addr[1:0];
            unf_n = 1'b1;
          end
        end
        default:    pc_n = seq;
      endcase
    end
  end

  // Control state and registered status/pulse outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_VECTOR;
      epc           <= '0;
      ptr           <= '0;
      cnt           <= '0;
      ras_empty     <= 1'b1;
      ras_full      <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      misaligned    <= 1'b0;
    end else begin
      pc            <= pc_n;
      epc           <= epc_n;
      ptr           <= ptr_n;
      cnt           <= cnt_n;
      ras_empty     <= (cnt_n == '0);
      ras_full      <= (cnt_n == CW'(RAS_DEPTH));
      ras_overflow  <= ovf_n;
      ras_underflow <= unf_n;
      misaligned    <= mis_n;
    end
  end

  // RAS storage; contents are don't-care after reset so no reset is needed
  always_ff @(posedge clk) begin
    if (push) ras[ptr_n] <= seq;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized + directed bench for pc_sequencer against a queue-based model.
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h0;
  localparam logic [31:0] EXV = 32'h0000_0180;
  localparam int          DEP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  pc_sel;
  logic [31:0] reg_addr;
  logic [15:0] branch_offset;
  logic [25:0] jump_addr;
  logic        exc_req;
  logic [31:0] pc, epc;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow, misaligned;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf, m_mis;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .EXC_VECTOR(EXV), .RAS_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .reg_addr(reg_addr),
    .branch_offset(branch_offset), .jump_addr(jump_addr), .exc_req(exc_req),
    .pc(pc), .epc(epc), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_epc = 0; m_ras.delete();
    m_ovf = 0; m_unf = 0; m_mis = 0;
  endtask

  // Behavioural next-PC rules with a LIFO queue as the return stack
  task automatic model_edge();
    logic [31:0] seq, tgt;
    m_ovf = 0; m_unf = 0; m_mis = 0;
    seq = m_pc + 32'd4;
    if (exc_req) begin
      m_epc = m_pc;
      m_pc  = EXV;
    end else if (!stall) begin
      case (pc_sel)
        3'd1: m_pc = {m_pc[31:28], jump_addr, 2'b00};
        3'd2: begin
          m_mis = (reg_addr % 4) != 0;
          m_pc  = reg_addr & ~32'd3;
        end
        3'd3: m_pc = seq + 32'($signed(branch_offset)) * 32'd4;
        3'd4: begin
          m_ras.push_back(seq);
          if (m_ras.size() > DEP) begin
            void'(m_ras.pop_front());
            m_ovf = 1;
          end
          m_pc = {m_pc[31:28], jump_addr, 2'b00};
        end
        3'd5: begin
          if (m_ras.size() > 0) tgt = m_ras.pop_back();
          else begin
            tgt   = reg_addr;
            m_unf = 1;
          end
          m_mis = (tgt % 4) != 0;
          m_pc  = tgt & ~32'd3;
        end
        default: m_pc = seq;
      endcase
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("epc", epc, m_epc);
    check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    check("ras_full", 32'(ras_full), 32'(m_ras.size() == DEP));
    check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
    check("misaligned", 32'(misaligned), 32'(m_mis));
  endtask

  // One clock: inputs already driven; update model at the edge, sample 1 time unit later
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [2:0] sel, input logic [25:0] ja, input logic [31:0] ra,
                       input logic [15:0] bo, input logic st, input logic ex);
    pc_sel = sel; jump_addr = ja; reg_addr = ra; branch_offset = bo; stall = st; exc_req = ex;
  endtask

  // Mid-cycle asynchronous reset, checked before the next edge, released mid-cycle
  task automatic async_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("async_pc", pc, RV);
    check("async_empty", 32'(ras_empty), 32'd1);
    check("async_epc", epc, 32'd0);
    step();
    rst = 1'b0;
  endtask

  int ovf_seen;

  initial begin
    rst = 1'b1;
    drive(3'd0, '0, '0, '0, 1'b0, 1'b0);
    model_reset();
    #1;
    compare_all();
    step();
    rst = 1'b0;

    // SEQ from reset: 0, 4, 8, 12
    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq_pc", pc, 32'(4 * i));
    end
    check("seq_empty", 32'(ras_empty), 32'd1);

    // Backward branch by one word lands back on the same PC
    drive(3'd1, 26'h010_0004, '0, '0, 1'b0, 1'b0); step();
    check("jump_to_400010", pc, 32'h0040_0010);
    drive(3'd3, '0, '0, 16'hFFFF, 1'b0, 1'b0); step();
    check("branch_m1", pc, 32'h0040_0010);
    drive(3'd2, '0, 32'h1000_0000, '0, 1'b0, 1'b0); step();
    drive(3'd1, 26'h000_0100, '0, '0, 1'b0, 1'b0); step();
    check("jump_region", pc, 32'h1000_0400);

    // Five calls overflow a 4-deep stack exactly once
    ovf_seen = 0;
    for (int i = 0; i < 5; i++) begin
      drive(3'd4, 26'(32'h100 * (i + 1)), '0, '0, 1'b0, 1'b0);
      step();
      if (ras_overflow) ovf_seen++;
      if (i == 4) check("ovf_on_5th", 32'(ras_overflow), 32'd1);
    end
    check("ovf_count", 32'(ovf_seen), 32'd1);
    check("full_after_5", 32'(ras_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(3'd5, '0, '0, '0, 1'b0, 1'b0);
      step();
    end
    drive(3'd5, '0, 32'h0000_2002, '0, 1'b0, 1'b0); step();
    check("underflow_pc", pc, 32'h0000_2000);
    check("underflow_pulse", 32'(ras_underflow), 32'd1);
    check("underflow_mis", 32'(misaligned), 32'd1);

    // Stalled CALL holds everything, then executes once
    for (int i = 0; i < 3; i++) begin
      drive(3'd4, 26'h55, '0, '0, 1'b1, 1'b0);
      step();
      check("stall_pc", pc, 32'h0000_2000);
    end
    drive(3'd4, 26'h55, '0, '0, 1'b0, 1'b0); step();
    drive(3'd0, '0, '0, '0, 1'b0, 1'b0); step();
    check("call_once_empty", 32'(ras_empty), 32'd0);

    // Exception wins over stall
    drive(3'd2, '0, 32'h0000_0100, '0, 1'b0, 1'b0); step();
    drive(3'd4, '0, '0, '0, 1'b1, 1'b1); step();
    check("exc_pc", pc, EXV);
    check("exc_epc", epc, 32'h0000_0100);

    // Consecutive CALL then RET returns the just-pushed value
    drive(3'd4, 26'h40, '0, '0, 1'b0, 1'b0); step();
    drive(3'd5, '0, '0, '0, 1'b0, 1'b0); step();
    check("call_ret", pc, 32'h0000_0184);

    // Async reset after two calls
    drive(3'd4, 26'h10, '0, '0, 1'b0, 1'b0); step();
    drive(3'd4, 26'h20, '0, '0, 1'b0, 1'b0); step();
    async_reset();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(3'($urandom_range(0, 7)), 26'($urandom),
            ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & ~32'd3),
            16'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 99) == 0) async_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised next-generation program counter for the single-cycle MIPS datapath. It owns the fetch address register and adds several features: stall hold, an exception redirect with saved EPC, a configurable return-address stack (RAS) for call/return, and alignment checking of register targets. It sits between the control unit, which drives `pc_sel`, `stall` and `exc_req`, and instruction memory, which consumes `pc`.

## Interface
- `XLEN`, 32: PC/address width; must be ≥ 32.
- `RESET_VECTOR`, 0: PC value while/after reset.
- `EXC_VECTOR`, 32'h0000_0180: exception handler address (XLEN bits).
- `RAS_DEPTH`, 4: return-address stack entries; must be a power of two, ≥ 2.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: hold all state this cycle.
- `pc_sel` in 3: next-PC mode (see Operation).
- `reg_addr` in XLEN: register jump target (jr/jalr).
- `branch_offset` in 16: branch immediate, in words.
- `jump_addr` in 26: jump index field.
- `exc_req` in 1: exception redirect request.
- `pc` out XLEN: current fetch address.
- `epc` out XLEN: PC of the instruction at the last exception.
- `ras_empty` out 1: RAS holds 0 entries.
- `ras_full` out 1: RAS holds RAS_DEPTH entries.
- `ras_overflow` out 1: one-cycle pulse, a push discarded the oldest entry.
- `ras_underflow` out 1: one-cycle pulse, a return popped an empty RAS.
- `misaligned` out 1: one-cycle pulse, a register/RAS target had nonzero bits [1:0].

## Operation
- `seq` = pc + 4; all arithmetic is modulo 2^XLEN.
- `pc_sel` modes:
  - 000 SEQ: `pc <= seq`.
  - 001 JUMP: `pc <= {pc[XLEN-1:28], jump_addr, 2'b00}`.
  - 010 JREG: `pc <= {reg_addr[XLEN-1:2], 2'b00}`. If `reg_addr[1:0]` ≠ 0, pulse `misaligned`.
  - 011 BRANCH: `pc <= seq + (sext(branch_offset) << 2)`.
  - 100 CALL: JUMP target; push `seq` to the RAS.
  - 101 RET: if the RAS is non-empty, pop and `pc <=` top entry with bits [1:0] cleared. If empty, use the JREG target and pulse `ras_underflow`. Apply the misaligned check to whichever target is selected.
  - 110, 111: reserved; behave as SEQ.
- Priority: `rst` > `exc_req` > `stall` > `pc_sel`.
- On `exc_req`: `epc <= pc`, `pc <= EXC_VECTOR`, the RAS is unchanged, and `stall` and `pc_sel` are ignored.
- On `stall` (without `exc_req`): `pc`, `epc` and the RAS hold. No pulses are generated.
- RAS is a circular buffer with a top pointer and a count in 0..RAS_DEPTH:
  - Push when full: the oldest entry is overwritten, count stays at RAS_DEPTH, and `ras_overflow` pulses.
  - Pop: count decrements and the top pointer moves back.
- Reset values: `pc` = RESET_VECTOR, `epc` = 0, RAS count = 0, pointer = 0, all pulses = 0, `ras_empty` = 1, `ras_full` = 0. RAS entry contents after reset are don't-care.

## Timing
- All state updates on the rising edge of `clk`; `rst` clears state immediately and asynchronously.
- `pc` is registered. A `pc_sel` decision presented in cycle N appears on `pc` after the edge ending cycle N, so latency is 1.
- `ras_empty` and `ras_full` are registered-state decodes, valid in the same cycle as the count.
- `ras_overflow`, `ras_underflow` and `misaligned` are registered and high for exactly one cycle after the causing edge.
- Deasserting `rst` mid-operation: the first edge after release applies `pc_sel` to RESET_VECTOR.
- Simultaneous `exc_req` and `stall`: the exception wins.
- CALL and RET in consecutive cycles: the pop returns the value just pushed.

## Test plan
- Reset, then 3 cycles of SEQ → `pc` steps 0, 4, 8, 12; `ras_empty` = 1.
- At `pc` = 0x0040_0010, BRANCH with `branch_offset` = 16'hFFFF → `pc` = 0x0040_0010. At `pc` = 0x1000_0000, JUMP with `jump_addr` = 0x0000_100 → `pc` = 0x1000_0400.
- With RAS_DEPTH = 4, perform 5 CALLs from distinct PCs → `ras_overflow` pulses once, on the 5th. Then 4 RETs return the last four `seq` values in LIFO order. A 5th RET with `reg_addr` = 0x0000_2002 → `pc` = 0x0000_2000, and `ras_underflow` and `misaligned` both pulse.
- `stall` held 3 cycles while CALL is presented → `pc` and RAS count unchanged and no pulses. After release, the CALL executes once.
- At `pc` = 0x0000_0100, `exc_req` with `stall` = 1 → `pc` = EXC_VECTOR, `epc` = 0x0000_0100, RAS count unchanged.
- Assert `rst` asynchronously mid-cycle after 2 CALLs → `pc` = RESET_VECTOR before the next edge, `ras_empty` = 1, `epc` = 0.
